// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - RV32I execute-stage ALU with serial shifter and valid/ready handshake
//
// Purpose: computes the integer ALU result for the 4-bit {funct7_fix, funct3}
// operation code. Shifts run on an iterative 1-bit/cycle engine when
// SERIAL_SHIFT=1, so both sides use a valid/ready handshake.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flush             kills any in-flight shift and pending result
//   in_valid/in_ready input handshake for operation, op_a, op_b
//   out_valid/out_ready output handshake for result, zero, illegal_op
//   result            registered ALU result
//   zero              result == 0
//   illegal_op        operation code not decoded (valid with out_valid)
//   busy              serial shift in progress
module alu_exec_unit #(
  parameter int XLEN         = 32,
  parameter bit SERIAL_SHIFT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      operation,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal_op,
  output logic            busy
);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [4:0]      count_q, count_d;
  logic            left_q, left_d;
  logic            arith_q, arith_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] alu_res;
  logic            alu_illegal;
  logic            is_shift;
  logic            shift_left;
  logic            shift_arith;
  logic [4:0]      shamt;
  logic            accept;
  logic [XLEN-1:0] step;

  // One-bit shift step shared by the accept cycle and the SHIFT state.
  function automatic logic [XLEN-1:0] shift1(input logic [XLEN-1:0] v,
                                             input logic left,
                                             input logic arith);
    if (left) shift1 = {v[XLEN-2:0], 1'b0};
    else      shift1 = {arith & v[XLEN-1], v[XLEN-1:1]};
  endfunction

  assign shamt    = op_b[4:0];
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign step     = shift1(work_q, left_q, arith_q);

  // Decode and single-cycle datapath. In serial mode only shamt 0/1 results
  // come from here; longer shifts are handed to the iterative engine.
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    is_shift    = 1'b0;
    shift_left  = 1'b0;
    shift_arith = 1'b0;
    case (operation)
      4'b0000: alu_res = op_a + op_b;
      4'b1000: alu_res = op_a - op_b;
      4'b0010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b0011: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      4'b0100: alu_res = op_a ^ op_b;
      4'b0110: alu_res = op_a | op_b;
      4'b0111: alu_res = op_a & op_b;
      4'b0001, 4'b0101, 4'b1101: begin
        is_shift    = 1'b1;
        shift_left  = (operation == 4'b0001);
        shift_arith = (operation == 4'b1101);
        if (SERIAL_SHIFT) begin
          alu_res = (shamt == 5'd0) ? op_a : shift1(op_a, shift_left, shift_arith);
        end else if (shift_left) begin
          alu_res = op_a << shamt;
        end else if (shift_arith) begin
          alu_res = XLEN'($signed(op_a) >>> shamt);
        end else begin
          alu_res = op_a >> shamt;
        end
      end
      default: alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    count_d     = count_q;
    left_d      = left_q;
    arith_d     = arith_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;

    if (flush) begin
      state_d     = S_IDLE;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (SERIAL_SHIFT && is_shift && (shamt > 5'd1)) begin
              // First bit is shifted on the accept edge, so the engine needs
              // shamt-1 more cycles: total latency equals shamt.
              state_d = S_SHIFT;
              work_d  = shift1(op_a, shift_left, shift_arith);
              count_d = shamt - 5'd1;
              left_d  = shift_left;
              arith_d = shift_arith;
            end else begin
              out_valid_d = 1'b1;
              result_d    = alu_res;
              zero_d      = (alu_res == '0);
              illegal_d   = alu_illegal;
            end
          end
        end
        S_SHIFT: begin
          work_d  = step;
          count_d = count_q - 5'd1;
          if (count_q == 5'd1) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b1;
            result_d    = step;
            zero_d      = (step == '0);
            illegal_d   = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      work_q      <= '0;
      count_q     <= '0;
      left_q      <= 1'b0;
      arith_q     <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      count_q     <= count_d;
      left_q      <= left_d;
      arith_q     <= arith_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign zero       = zero_q;
  assign illegal_op = illegal_q;
  assign busy       = (state_q == S_SHIFT);

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal_op;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .SERIAL_SHIFT(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal_op(illegal_op), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic from the RV32I definitions.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    int     sh = int'(b[4:0]);
    longint p  = longint'(1) << sh;
    ill = 1'b0;
    lat = 1;
    r   = 32'h0;
    case (op)
      4'b0000: r = a + b;
      4'b1000: r = a - b;
      4'b0010: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'b0011: r = (a < b) ? 32'd1 : 32'd0;
      4'b0100: r = a ^ b;
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      4'b0001: begin r = 32'(longint'(a) * p); lat = (sh == 0) ? 1 : sh; end
      4'b0101: begin r = 32'(longint'(a) / p); lat = (sh == 0) ? 1 : sh; end
      4'b1101: begin
        r = 32'(longint'(a) / p) | (a[31] ? ~32'(64'hFFFF_FFFF / p) : 32'h0);
        lat = (sh == 0) ? 1 : sh;
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // Present one op and return once it has been accepted (inputs then idle).
  task automatic accept_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    operation = op; op_a = a; op_b = b; in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    check("accept_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_r;
    logic        exp_ill;
    int          exp_lat;
    int          lat = 1;
    int          busy_cycles = 0;
    model(op, a, b, exp_r, exp_ill, exp_lat);
    accept_op(op, a, b);
    while (!out_valid && lat < 100) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1; lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, busy_cycles, exp_lat - 1);
    check({tag, "_res"}, result, exp_r);
    check({tag, "_zero"}, {31'b0, zero}, {31'b0, (exp_r == 32'h0)});
    check({tag, "_ill"}, {31'b0, illegal_op}, {31'b0, exp_ill});
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int          seen;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    operation = 4'h0; op_a = 32'h0; op_b = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_result", result, 32'h0);

    // Reset mid-shift
    accept_op(4'b0001, 32'h1, 32'd20);
    repeat (4) begin @(posedge clk); #1; end
    check("midshift_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    check("rst2_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst2_busy", {31'b0, busy}, 32'd0);
    check("rst2_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst2_result", result, 32'h0);

    // Directed ALU ops
    run_op("add_wrap", 4'b0000, 32'h7FFF_FFFF, 32'h1);
    run_op("sub_zero", 4'b1000, 32'd5, 32'd5);
    run_op("slt", 4'b0010, 32'hFFFF_FFFF, 32'h1);
    run_op("sltu", 4'b0011, 32'hFFFF_FFFF, 32'h1);
    run_op("and", 4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run_op("or", 4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run_op("xor", 4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0);

    // Serial shifts
    run_op("sra31", 4'b1101, 32'h8000_0000, 32'd31);
    run_op("srl31", 4'b0101, 32'h8000_0000, 32'd31);
    run_op("sll0", 4'b0001, 32'h1, 32'd0);
    run_op("sll1", 4'b0001, 32'h1, 32'd1);
    run_op("srl_b25", 4'b0101, 32'h0000_00F0, 32'h25);

    // Illegal code, then a legal op clears illegal_op
    run_op("illegal", 4'b1010, 32'd3, 32'd4);
    run_op("after_ill", 4'b0000, 32'd3, 32'd4);

    // Backpressure
    @(posedge clk); #1;
    out_ready = 1'b0;
    accept_op(4'b0000, 32'd2, 32'd3);
    check("bp_first_valid", {31'b0, out_valid}, 32'd1);
    operation = 4'b1000; op_a = 32'd20; op_b = 32'd4; in_valid = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("bp_hold_res", result, 32'd5);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_valid", {31'b0, out_valid}, 32'd1);
    check("bp_second_res", result, 32'd16);
    @(posedge clk); #1;

    // Flush during a serial shift
    accept_op(4'b0001, 32'h1, 32'd10);
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    seen = 0;
    repeat (15) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("flush_no_result", seen, 0);

    // Flush with an op presented in the same cycle
    operation = 4'b0000; op_a = 32'd7; op_b = 32'd8; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    seen = 0;
    repeat (3) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("flush_drop", seen, 0);

    // Randomized ops against the model
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) ra = rb;
      run_op($sformatf("rnd%0d_op%0h", i, rop), rop, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
